// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 stream selector family.
package mux_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;
    localparam int NCH_MAX  = 16;

    // Minimum width of 1 so that a 1-channel index still has a bit to live in.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first requester at or above ptr, wrapping modulo NCH.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int SELW = clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_vld
);

    logic [2*NCH-1:0] req_dbl;
    logic [NCH-1:0]   req_win;
    logic [SELW-1:0]  off;
    logic [SELW:0]    sum;

    // Doubling the request vector turns the modulo search into a plain window.
    assign req_dbl = {req, req};
    assign req_win = req_dbl[ptr +: NCH];

    always_comb begin
        gnt_vld = 1'b0;
        off     = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (req_win[k]) begin
                gnt_vld = 1'b1;
                off     = SELW'(k);
            end
        end
    end

    assign sum     = {1'b0, ptr} + {1'b0, off};
    assign gnt_idx = (sum >= (SELW+1)'(NCH)) ? SELW'(sum - (SELW+1)'(NCH)) : sum[SELW-1:0];

endmodule

// File: rtl/stream_mux_n.sv
// N:1 valid/ready selector with a single registered output stage.
// Channel chosen by explicit sel (MODE_SEL) or round-robin over valid inputs (MODE_RR).
module stream_mux_n
    import mux_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int NCH   = 4,
    parameter int SELW  = clog2(NCH),
    parameter int MODE  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    input  logic                 out_ready
);

    logic             out_valid_reg, out_valid_next;
    logic [WIDTH-1:0] out_data_reg, out_data_next;
    logic [SELW-1:0]  out_ch_reg, out_ch_next;
    logic [SELW-1:0]  rr_ptr_reg, rr_ptr_next;

    logic [SELW-1:0]  gnt_idx;
    logic             gnt_vld;
    logic             can_load;
    logic             load;
    logic [WIDTH-1:0] ch_data [NCH];

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic unused_sel;
            assign unused_sel = ^sel;

            rr_arbiter #(
                .NCH  (NCH),
                .SELW (SELW)
            ) u_arb (
                .req     (in_valid),
                .ptr     (rr_ptr_reg),
                .gnt_idx (gnt_idx),
                .gnt_vld (gnt_vld)
            );
        end else begin : g_sel
            // Out-of-range select (non power-of-two NCH) grants nobody.
            assign gnt_idx = sel;
            assign gnt_vld = ({1'b0, sel} < (SELW+1)'(NCH));
        end
    endgenerate

    assign can_load = !out_valid_reg || out_ready;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            assign ch_data[gi]  = in_data[gi*WIDTH +: WIDTH];
            assign in_ready[gi] = can_load && gnt_vld && (gnt_idx == SELW'(gi)) && rst_n;
        end
    endgenerate

    assign load = |(in_valid & in_ready);

    always_comb begin
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_ch_next    = out_ch_reg;
        rr_ptr_next    = rr_ptr_reg;
        if (load) begin
            out_valid_next = 1'b1;
            out_data_next  = ch_data[gnt_idx];
            out_ch_next    = gnt_idx;
            rr_ptr_next    = (gnt_idx == SELW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
            rr_ptr_reg    <= '0;
        end else begin
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_ch_reg    <= out_ch_next;
            rr_ptr_reg    <= rr_ptr_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_ch    = out_ch_reg;

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: three instances (4ch select, 4ch round-robin, 3ch select)
// checked against a cycle-level behavioural model with directed and random phases.
module tb_stream_mux_n;

    localparam int W = 20;
    localparam int NCH_OF  [3] = '{4, 4, 3};
    localparam int MODE_OF [3] = '{0, 1, 0};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bit [3:0]   v_valid  [3];
    bit [W-1:0] v_data   [3][4];
    bit [1:0]   v_sel    [3];
    bit         v_oready [3];

    int obs_ready [3];
    int obs_valid [3];
    int obs_data  [3];
    int obs_ch    [3];

    bit m_valid [3];
    int m_data  [3];
    int m_ch    [3];
    int m_ptr   [3];

    bit got_in   [3];
    bit got_out  [3];
    int got_data [3];
    int got_ch   [3];

    int tests_run    = 0;
    int tests_failed = 0;

    logic [3:0]   a_in_valid, a_in_ready, b_in_valid, b_in_ready;
    logic [2:0]   c_in_valid, c_in_ready;
    logic [4*W-1:0] a_in_data, b_in_data;
    logic [3*W-1:0] c_in_data;
    logic [1:0]   a_sel, b_sel, c_sel, a_out_ch, b_out_ch, c_out_ch;
    logic         a_out_valid, b_out_valid, c_out_valid;
    logic         a_out_ready, b_out_ready, c_out_ready;
    logic [W-1:0] a_out_data, b_out_data, c_out_data;

    assign a_in_valid  = v_valid[0];
    assign b_in_valid  = v_valid[1];
    assign c_in_valid  = v_valid[2][2:0];
    assign a_sel       = v_sel[0];
    assign b_sel       = v_sel[1];
    assign c_sel       = v_sel[2];
    assign a_out_ready = v_oready[0];
    assign b_out_ready = v_oready[1];
    assign c_out_ready = v_oready[2];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pack
            assign a_in_data[gi*W +: W] = v_data[0][gi];
            assign b_in_data[gi*W +: W] = v_data[1][gi];
            if (gi < 3) begin : g_c
                assign c_in_data[gi*W +: W] = v_data[2][gi];
            end
        end
    endgenerate

    assign obs_ready[0] = int'(a_in_ready);
    assign obs_ready[1] = int'(b_in_ready);
    assign obs_ready[2] = int'(c_in_ready);
    assign obs_valid[0] = int'(a_out_valid);
    assign obs_valid[1] = int'(b_out_valid);
    assign obs_valid[2] = int'(c_out_valid);
    assign obs_data[0]  = int'(a_out_data);
    assign obs_data[1]  = int'(b_out_data);
    assign obs_data[2]  = int'(c_out_data);
    assign obs_ch[0]    = int'(a_out_ch);
    assign obs_ch[1]    = int'(b_out_ch);
    assign obs_ch[2]    = int'(c_out_ch);

    stream_mux_n #(.WIDTH(W), .NCH(4), .MODE(0)) u_sel4 (
        .clk(clk), .rst_n(rst_n), .sel(a_sel), .in_valid(a_in_valid), .in_data(a_in_data),
        .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
        .out_ch(a_out_ch), .out_ready(a_out_ready)
    );

    stream_mux_n #(.WIDTH(W), .NCH(4), .MODE(1)) u_rr4 (
        .clk(clk), .rst_n(rst_n), .sel(b_sel), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
        .out_ch(b_out_ch), .out_ready(b_out_ready)
    );

    stream_mux_n #(.WIDTH(W), .NCH(3), .MODE(0)) u_sel3 (
        .clk(clk), .rst_n(rst_n), .sel(c_sel), .in_valid(c_in_valid), .in_data(c_in_data),
        .in_ready(c_in_ready), .out_valid(c_out_valid), .out_data(c_out_data),
        .out_ch(c_out_ch), .out_ready(c_out_ready)
    );

    task automatic check(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Who would win right now: the selected channel, or the first valid one from the pointer.
    function automatic int model_grant(input int k);
        if (MODE_OF[k] == 0) begin
            return (int'(v_sel[k]) < NCH_OF[k]) ? int'(v_sel[k]) : -1;
        end
        for (int o = 0; o < NCH_OF[k]; o++) begin
            int c;
            c = (m_ptr[k] + o) % NCH_OF[k];
            if (v_valid[k][c]) begin
                return c;
            end
        end
        return -1;
    endfunction

    // One clock: check in_ready before the edge, advance the model, check outputs after.
    task automatic step();
        int g  [3];
        int er [3];
        #1;
        for (int k = 0; k < 3; k++) begin
            g[k]  = model_grant(k);
            er[k] = (rst_n && (!m_valid[k] || v_oready[k]) && g[k] >= 0) ? (1 << g[k]) : 0;
            check($sformatf("u%0d_in_ready", k), obs_ready[k], er[k]);
            got_in[k]   = (g[k] >= 0) && (er[k] != 0) && v_valid[k][g[k]];
            got_out[k]  = rst_n && m_valid[k] && v_oready[k];
            got_data[k] = obs_data[k];
            got_ch[k]   = obs_ch[k];
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (got_out[k]) begin
                $display("[TB] u%0d out ch=%0d data=%05h", k, got_ch[k], got_data[k]);
            end
            if (!rst_n) begin
                m_valid[k] = 1'b0;
                m_data[k]  = 0;
                m_ch[k]    = 0;
                m_ptr[k]   = 0;
            end else if (got_in[k]) begin
                m_valid[k] = 1'b1;
                m_data[k]  = int'(v_data[k][g[k]]);
                m_ch[k]    = g[k];
                m_ptr[k]   = (g[k] + 1) % NCH_OF[k];
            end else if (v_oready[k]) begin
                m_valid[k] = 1'b0;
            end
            check($sformatf("u%0d_out_valid", k), obs_valid[k], int'(m_valid[k]));
            check($sformatf("u%0d_out_data", k), obs_data[k], m_data[k]);
            check($sformatf("u%0d_out_ch", k), obs_ch[k], m_ch[k]);
        end
    endtask

    int bp_q[$];
    int n;
    int rr_seq [3] = '{0, 1, 3};
    int bp_seq [3] = '{1, 2, 3};

    initial begin
        for (int k = 0; k < 3; k++) begin
            v_valid[k]  = 4'hF;
            v_sel[k]    = 2'd0;
            v_oready[k] = 1'b0;
            m_valid[k]  = 1'b0;
            m_data[k]   = 0;
            m_ch[k]     = 0;
            m_ptr[k]    = 0;
            for (int c = 0; c < 4; c++) v_data[k][c] = W'($urandom);
        end

        // Reset held with every input valid
        rst_n = 1'b0;
        repeat (3) begin
            step();
            for (int k = 0; k < 3; k++) begin
                check("rst_valid", obs_valid[k], 0);
                check("rst_ready", obs_ready[k], 0);
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) v_valid[k] = 4'h0;

        // Explicit select of channel 2
        v_sel[0] = 2'd2;
        v_data[0][2] = 20'hABCDE;
        v_valid[0] = 4'b0100;
        v_oready[0] = 1'b1;
        repeat (3) begin
            step();
            check("m0_data", obs_data[0], 20'hABCDE);
            check("m0_ch", obs_ch[0], 2);
            check("m0_ready", obs_ready[0], 4'b0100);
        end

        // Backpressure on channel 1 with a three-word producer
        v_valid[0] = 4'h0;
        step();
        step();
        v_sel[0] = 2'd1;
        bp_q = '{1, 2, 3};
        n = 0;
        for (int cyc = 0; cyc < 30 && n < 3; cyc++) begin
            v_valid[0]   = (bp_q.size() > 0) ? 4'b0010 : 4'b0000;
            v_data[0][1] = (bp_q.size() > 0) ? W'(bp_q[0]) : '0;
            v_oready[0]  = (cyc >= 4);
            step();
            if (got_in[0]) void'(bp_q.pop_front());
            if (got_out[0]) begin
                check("bp_seq", got_data[0], bp_seq[n]);
                n++;
            end
            if (cyc >= 1 && cyc < 4) begin
                check("bp_hold", obs_data[0], 1);
                check("bp_ready", obs_ready[0], 0);
            end
        end
        check("bp_count", n, 3);
        v_valid[0] = 4'h0;

        // Round-robin over channels 0,1,3 with a stall in the middle
        v_valid[1] = 4'b1011;
        n = 0;
        for (int cyc = 0; cyc < 40 && n < 9; cyc++) begin
            for (int c = 0; c < 4; c++) v_data[1][c] = W'($urandom);
            v_oready[1] = !(cyc >= 7 && cyc < 10);
            step();
            if (got_out[1]) begin
                check("rr_seq", got_ch[1], rr_seq[n % 3]);
                n++;
            end
        end
        check("rr_count", n, 9);

        // Reset while a word is held under backpressure
        v_oready[1] = 1'b0;
        step();
        check("mr_held", obs_valid[1], 1);
        rst_n = 1'b0;
        step();
        check("mr_valid", obs_valid[1], 0);
        rst_n = 1'b1;
        v_oready[1] = 1'b1;
        step();
        check("mr_vld", obs_valid[1], 1);
        check("mr_ch", obs_ch[1], 0);

        // Out-of-range select on the 3-channel instance
        v_valid[2] = 4'b0111;
        v_sel[2] = 2'd0;
        v_oready[2] = 1'b1;
        step();
        check("oor_load", obs_valid[2], 1);
        v_sel[2] = 2'd3;
        repeat (4) begin
            step();
            check("oor_vld", obs_valid[2], 0);
            check("oor_rdy", obs_ready[2], 0);
        end

        // Random traffic, including occasional resets
        for (int cyc = 0; cyc < 400; cyc++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            for (int k = 0; k < 3; k++) begin
                v_valid[k]  = 4'($urandom);
                v_sel[k]    = 2'($urandom);
                v_oready[k] = ($urandom_range(0, 3) != 0);
                for (int c = 0; c < 4; c++) v_data[k][c] = W'($urandom);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
